scytale_decryption: RTL
=======================

Name: scytale_decryption

Overview:
- Scytale decryption engine. Sits directly downstream of the decryption register bank and consumes its 16-bit scytale_key.
- Collects ciphertext characters arriving from the input DEMUX into an internal buffer.
- On the start-decryption token, replays the buffer in scytale order to the output MUX at one character per cycle.
- Asserts busy while replaying so that upstream stalls.

Parameters:
- D_WIDTH, 8: character width in bits.
- KEY_WIDTH, 8: width of each key half (N and M).
- MAX_NOF_CHARS, 50: buffer depth in characters.
- START_DECRYPTION_TOKEN, 8'hFA: end-of-message / start-replay character.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset. Synchronous and active-high (asserted = 1), sampled on posedge clk.
- data_i  in  D_WIDTH  ciphertext character.
- valid_i  in  1  data_i qualifier; one character per cycle when high.
- key  in  2*KEY_WIDTH  scytale_key from the register bank. key[15:8] = N (columns per output group), key[7:0] = M (rows).
- busy  out  1  high while replaying; upstream must not present valid_i.
- data_o  out  D_WIDTH  decrypted character; 0 when valid_o is low.
- valid_o  out  1  data_o qualifier.
- err_o  out  1  one-cycle pulse on a rejected decryption.

Behaviour:
- Reset (rst_n = 1 at posedge): state = COLLECT; wr_cnt = 0; row = col = 0; busy = 0; valid_o = 0; data_o = 0; err_o = 0. Buffer contents are don't-care.
- Reset applies mid-replay too: output stops in the same cycle's update and the message is discarded.
- All outputs are registered.
- State COLLECT:
  - On valid_i with data_i != token and wr_cnt < MAX_NOF_CHARS: buf[wr_cnt] <= data_i, wr_cnt++.
  - On valid_i with data_i != token and wr_cnt == MAX_NOF_CHARS: character dropped silently, wr_cnt holds.
  - On valid_i with data_i == token and wr_cnt == 0: token ignored; no err_o, no busy.
  - On valid_i with data_i == token and wr_cnt > 0: latch N and M from key into kN and kM.
    - If kN == 0, kM == 0, or kN*kM != wr_cnt: pulse err_o the next cycle, clear wr_cnt, stay in COLLECT.
    - Otherwise go to REPLAY with row = col = 0.
  - The key is sampled only at token acceptance. Later register-bank writes do not affect an ongoing replay.
- State REPLAY, one output per cycle:
  - data_o = buf[row*kM + col], valid_o = 1, busy = 1.
  - Index order: row++ (wrapping at kN); on row wrap, col++.
  - Equivalently out[k] = buf[(k mod N)*M + k div N] for k = 0 .. N*M-1.
  - Use a running base address; no divider.
- Latency:
  - Token accepted at posedge t: busy = 1 and first valid_o = 1 are visible after posedge t+1.
  - Last character appears after posedge t+N*M.
  - After posedge t+N*M+1: busy = 0, valid_o = 0, data_o = 0, wr_cnt = 0, state = COLLECT.
- valid_i while busy = 1 is a protocol violation. Input is ignored and the buffer is not written.
- Width rules:
  - kN*kM is computed at 2*KEY_WIDTH bits before comparing with wr_cnt (clog2(MAX_NOF_CHARS+1) bits, zero-extended).
  - Address row*kM + col is held as an incrementing accumulator of clog2(MAX_NOF_CHARS) bits. It never exceeds wr_cnt-1 by construction.
- Register-bank reset key 0xFFFF (N = M = 255) gives 65025 != wr_cnt. The result is err_o, which is the intended behaviour when the key is unprogrammed.

Decomposition:
- Shared constants header/package (decryption_defs): D_WIDTH, KEY_WIDTH, MAX_NOF_CHARS, START_DECRYPTION_TOKEN, and the state encoding (COLLECT = 0, REPLAY = 1).
- caesar and zigzag blocks also use this package.
- One sub-module: scytale_char_buffer. It is a MAX_NOF_CHARS x D_WIDTH storage with one synchronous write port and one asynchronous read port, addressed by the FSM.
- Counters and FSM stay in scytale_decryption.

Test Plan:
1. Basic replay:
   - Stimulus: key = 16'h0203, stream "ACEBDF" (0x41,0x43,0x45,0x42,0x44,0x46), then 0xFA.
   - Response: busy high for 6 cycles; data_o = 0x41,0x42,0x43,0x44,0x45,0x46 on consecutive cycles; then busy = 0 and err_o never high.
2. Key mismatch:
   - Stimulus: key = 16'h0203, 5 characters, then 0xFA.
   - Response: single err_o pulse one cycle after the token, valid_o stays 0. A subsequent valid 6-character message decrypts correctly.
3. Token only:
   - Stimulus: 0xFA with an empty buffer.
   - Response: no busy, no err_o, no valid_o.
4. Overflow:
   - Stimulus: key = 16'h0A05, 52 characters 0x00..0x33, then 0xFA.
   - Response: characters 0x32 and 0x33 are dropped. 50 outputs, starting 0x00,0x05,0x0A,...,0x2D, then 0x01,... (first 10 outputs are 0x00 + 5k).
5. Reset mid-replay:
   - Stimulus: during test 1, assert rst_n = 1 on the 3rd output cycle.
   - Response: the next cycle shows busy = 0, valid_o = 0, data_o = 0. A new message decrypts from a clean buffer.
6. Key change during replay:
   - Stimulus: after the token of test 1, change key to 16'h0302 mid-replay.
   - Response: output sequence is unchanged ("ABCDEF").

Source files
------------

// File: rtl/decryption_defs_pkg.sv
// Constants and state encoding shared by the decryption engines (caesar, zigzag, scytale).
package decryption_defs;

    localparam int D_WIDTH       = 8;
    localparam int KEY_WIDTH     = 8;
    localparam int MAX_NOF_CHARS = 50;
    localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

    // Counter must reach MAX_NOF_CHARS itself; addresses only up to MAX_NOF_CHARS-1.
    localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
    localparam int ADDR_W = $clog2(MAX_NOF_CHARS);

    typedef enum logic {
        COLLECT = 1'b0,
        REPLAY  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/scytale_decryption_if.sv
// Character stream and key bundle between the DEMUX/register bank and the scytale engine.
interface scytale_decryption_if
    import decryption_defs::*;
;
    logic [D_WIDTH-1:0]     data_i;
    logic                   valid_i;
    logic [2*KEY_WIDTH-1:0] key;
    logic                   busy;
    logic [D_WIDTH-1:0]     data_o;
    logic                   valid_o;
    logic                   err_o;

    modport master (
        output data_i, valid_i, key,
        input  busy, data_o, valid_o, err_o
    );

    modport slave (
        input  data_i, valid_i, key,
        output busy, data_o, valid_o, err_o
    );

endinterface

// File: rtl/scytale_char_buffer.sv
// Ciphertext store: one synchronous write port, one asynchronous read port.
module scytale_char_buffer
    import decryption_defs::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data
);

    logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryption: buffers a message, then on the token replays it column-wise
// (out[k] = buf[(k mod N)*M + k div N]) at one character per cycle.
module scytale_decryption
    import decryption_defs::*;
(
    input  logic clk,
    input  logic rst_n,
    scytale_decryption_if.slave bus
);

    dec_state_t             state;
    logic [CNT_W-1:0]       wr_cnt;
    logic [KEY_WIDTH-1:0]   k_n;
    logic [KEY_WIDTH-1:0]   k_m;
    logic [KEY_WIDTH-1:0]   row;
    logic [KEY_WIDTH-1:0]   col;
    logic [ADDR_W-1:0]      rd_addr;
    logic [D_WIDTH-1:0]     rd_data;
    logic [KEY_WIDTH-1:0]   key_n;
    logic [KEY_WIDTH-1:0]   key_m;
    logic [2*KEY_WIDTH-1:0] key_prod;
    logic                   accept;
    logic                   is_token;
    logic                   wr_en;
    logic                   row_wrap;
    logic                   last_out;

    assign key_n    = bus.key[2*KEY_WIDTH-1:KEY_WIDTH];
    assign key_m    = bus.key[KEY_WIDTH-1:0];
    assign key_prod = (2*KEY_WIDTH)'(key_n) * (2*KEY_WIDTH)'(key_m);

    // The registered busy flag also blocks the one cycle after replay ends.
    assign accept   = (state == COLLECT) && !bus.busy && bus.valid_i;
    assign is_token = (bus.data_i == START_DECRYPTION_TOKEN);
    assign wr_en    = accept && !is_token && (wr_cnt < CNT_W'(MAX_NOF_CHARS));

    assign row_wrap = (row == k_n - KEY_WIDTH'(1));
    assign last_out = row_wrap && (col == k_m - KEY_WIDTH'(1));

    scytale_char_buffer u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (bus.data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // rd_addr tracks row*k_m + col: +k_m per row step, reloaded with the new column on wrap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= COLLECT;
            wr_cnt      <= '0;
            row         <= '0;
            col         <= '0;
            rd_addr     <= '0;
            k_n         <= '0;
            k_m         <= '0;
            bus.busy    <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.err_o <= 1'b0;
            case (state)
                COLLECT: begin
                    bus.busy    <= 1'b0;
                    bus.valid_o <= 1'b0;
                    bus.data_o  <= '0;
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end else if (accept && is_token && (wr_cnt != '0)) begin
                        k_n     <= key_n;
                        k_m     <= key_m;
                        row     <= '0;
                        col     <= '0;
                        rd_addr <= '0;
                        if ((key_n == '0) || (key_m == '0) ||
                            (key_prod != (2*KEY_WIDTH)'(wr_cnt))) begin
                            bus.err_o <= 1'b1;
                            wr_cnt    <= '0;
                        end else begin
                            state <= REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    bus.busy    <= 1'b1;
                    bus.valid_o <= 1'b1;
                    bus.data_o  <= rd_data;
                    if (last_out) begin
                        state  <= COLLECT;
                        wr_cnt <= '0;
                    end else if (row_wrap) begin
                        row     <= '0;
                        col     <= col + KEY_WIDTH'(1);
                        rd_addr <= ADDR_W'(col + KEY_WIDTH'(1));
                    end else begin
                        row     <= row + KEY_WIDTH'(1);
                        rd_addr <= rd_addr + ADDR_W'(k_m);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
